// File: rtl/inst_fetch_stage_pkg.sv
// Shared fetch-stage constants, FSM state encoding and PC helpers.
package inst_fetch_stage_pkg;

    localparam int PC_WIDTH   = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_e;

    function automatic logic [PC_WIDTH-1:0] word_align(
        input logic [PC_WIDTH-1:0] a
    );
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_stage_fetch_pc_gen.sv
// Fetch PC register with next-PC select: hold, sequential +4, or redirect.
module fetch_pc_gen
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [PC_WIDTH-1:0] i_redirect_pc,
    output logic [PC_WIDTH-1:0] o_fetch_pc
);

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] w_next_pc;

    // Redirect outranks stall so a flush is never lost behind a held word.
    always_comb begin
        w_next_pc = r_fetch_pc;
        if (i_redirect) begin
            w_next_pc = word_align(i_redirect_pc);
        end else if (!i_stall) begin
            w_next_pc = r_fetch_pc + PC_STEP;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= word_align(RESET_PC);
        end else begin
            r_fetch_pc <= w_next_pc;
        end
    end

    assign o_fetch_pc = r_fetch_pc;

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a sync-read imem whose
// output register doubles as the IF/ID register.
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [PC_WIDTH-1:0]   i_redirect_pc,
    output logic [PC_WIDTH-1:0]   o_imem_addr,
    output logic                  o_imem_req,
    input  logic [INST_WIDTH-1:0] i_imem_rdata,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic [PC_WIDTH-1:0]   o_pc_plus4,
    output logic                  o_valid,
    output logic [31:0]           o_fetch_count
);

    fetch_state_e        r_state;
    logic [PC_WIDTH-1:0] r_pc_d;
    logic [31:0]         r_fetch_count;

    logic [PC_WIDTH-1:0] w_fetch_pc;
    logic                w_valid;
    logic                w_advance;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fetch_pc    (w_fetch_pc)
    );

    assign w_valid   = (r_state == ST_FULL);
    assign w_advance = !i_stall && !i_redirect;

    // A read is issued only on a true advance so rdata holds otherwise.
    assign o_imem_req    = !i_rst && w_advance;
    assign o_imem_addr   = w_fetch_pc;
    assign o_inst        = w_valid ? i_imem_rdata : NOP_INST;
    assign o_pc          = r_pc_d;
    assign o_pc_plus4    = r_pc_d + PC_STEP;
    assign o_valid       = w_valid;
    assign o_fetch_count = r_fetch_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_EMPTY;
            r_pc_d        <= '0;
            r_fetch_count <= '0;
        end else begin
            if (i_redirect) begin
                r_state <= ST_EMPTY;
            end else if (!i_stall) begin
                r_state <= ST_FULL;
                r_pc_d  <= w_fetch_pc;
                if (w_valid) begin
                    r_fetch_count <= r_fetch_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed vector table,
// async-reset sequences and randomized run against a stream model.
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] rpc = 32'h0;

    logic [31:0] addr0, inst0, pc0, pc4_0, cnt0;
    logic [31:0] rdata0 = 32'h0;
    logic        req0, valid0;

    logic [31:0] addr1, inst1, pc1, pc4_1, cnt1;
    logic [31:0] rdata1 = 32'h0;
    logic        req1, valid1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inst_fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (rpc),
        .o_imem_addr   (addr0),
        .o_imem_req    (req0),
        .i_imem_rdata  (rdata0),
        .o_inst        (inst0),
        .o_pc          (pc0),
        .o_pc_plus4    (pc4_0),
        .o_valid       (valid0),
        .o_fetch_count (cnt0)
    );

    inst_fetch_stage #(.RESET_PC(32'h0040_0000)) dut1 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (rpc),
        .o_imem_addr   (addr1),
        .o_imem_req    (req1),
        .i_imem_rdata  (rdata1),
        .o_inst        (inst1),
        .o_pc          (pc1),
        .o_pc_plus4    (pc4_1),
        .o_valid       (valid1),
        .o_fetch_count (cnt1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8462_AC42;
        if (a == 32'h4) return 32'h8046_AC02;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_1E0F;
    endfunction

    always @(posedge clk) if (req0) rdata0 <= mem_word(addr0);
    always @(posedge clk) if (req1) rdata1 <= mem_word(addr1);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        stall;
        logic        red;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_req;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic s, input logic r, input logic [31:0] t,
        input logic v, input logic [31:0] p, input logic [31:0] a,
        input logic q, input logic [31:0] c
    );
        vec_t x;
        x.stall   = s;
        x.red     = r;
        x.rpc     = t;
        x.e_valid = v;
        x.e_inst  = v ? mem_word(p) : 32'h0;
        x.e_pc    = p;
        x.e_addr  = a;
        x.e_req   = q;
        x.e_cnt   = c;
        return x;
    endfunction

    vec_t vecs [18];

    // Reference model of the delivered stream
    logic [31:0] m_next, m_pc, m_cnt;
    logic        m_valid;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 0, 0,    0, 32'h000, 32'h000, 1, 0);
        vecs[1]  = mk(0, 0, 0,    1, 32'h000, 32'h004, 1, 0);
        vecs[2]  = mk(1, 0, 0,    1, 32'h004, 32'h008, 0, 1);
        vecs[3]  = mk(1, 0, 0,    1, 32'h004, 32'h008, 0, 1);
        vecs[4]  = mk(1, 0, 0,    1, 32'h004, 32'h008, 0, 1);
        vecs[5]  = mk(0, 0, 0,    1, 32'h004, 32'h008, 1, 1);
        vecs[6]  = mk(0, 0, 0,    1, 32'h008, 32'h00C, 1, 2);
        vecs[7]  = mk(0, 1, 32'h103, 1, 32'h00C, 32'h010, 0, 3);
        vecs[8]  = mk(0, 0, 0,    0, 32'h00C, 32'h100, 1, 3);
        vecs[9]  = mk(0, 0, 0,    1, 32'h100, 32'h104, 1, 3);
        vecs[10] = mk(1, 1, 32'hFFFF_FFFC,
                      1, 32'h104, 32'h108, 0, 4);
        vecs[11] = mk(0, 0, 0,    0, 32'h104, 32'hFFFF_FFFC, 1, 4);
        vecs[12] = mk(0, 0, 0,    1, 32'hFFFF_FFFC, 32'h000, 1, 4);
        vecs[13] = mk(0, 0, 0,    1, 32'h000, 32'h004, 1, 5);
        vecs[14] = mk(0, 1, 32'h020, 1, 32'h004, 32'h008, 0, 6);
        vecs[15] = mk(0, 1, 32'h041, 0, 32'h004, 32'h020, 0, 6);
        vecs[16] = mk(0, 0, 0,    0, 32'h004, 32'h040, 1, 6);
        vecs[17] = mk(0, 0, 0,    1, 32'h040, 32'h044, 1, 6);

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst valid0", {31'b0, valid0}, 32'h0);
            chk("rst inst0", inst0, 32'h0);
            chk("rst req0", {31'b0, req0}, 32'h0);
            chk("rst pc0", pc0, 32'h0);
            chk("rst pc4_0", pc4_0, 32'h4);
            chk("rst cnt0", cnt0, 32'h0);
            chk("rst valid1", {31'b0, valid1}, 32'h0);
            chk("rst inst1", inst1, 32'h0);
            chk("rst req1", {31'b0, req1}, 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            stall    = vecs[i].stall;
            redirect = vecs[i].red;
            rpc      = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d valid", i),
                {31'b0, valid0}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d inst", i), inst0, vecs[i].e_inst);
            chk($sformatf("v%0d pc", i), pc0, vecs[i].e_pc);
            chk($sformatf("v%0d pc4", i), pc4_0, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d addr", i), addr0, vecs[i].e_addr);
            chk($sformatf("v%0d req", i),
                {31'b0, req0}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d cnt", i), cnt0, vecs[i].e_cnt);
            if (i == 0) begin
                chk("rpc1 addr", addr1, 32'h0040_0000);
                chk("rpc1 req", {31'b0, req1}, 32'h1);
            end
            if (i == 1) begin
                chk("rpc1 valid", {31'b0, valid1}, 32'h1);
                chk("rpc1 pc", pc1, 32'h0040_0000);
                chk("rpc1 pc4", pc4_1, 32'h0040_0004);
            end
            @(negedge clk);
        end

        // Reset pulsed between edges mid-stream
        stall    = 1'b0;
        redirect = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst valid", {31'b0, valid0}, 32'h0);
        chk("arst cnt", cnt0, 32'h0);
        chk("arst pc", pc0, 32'h0);
        chk("arst inst", inst0, 32'h0);
        chk("arst req", {31'b0, req0}, 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("arst addr", addr0, 32'h0);
        chk("arst req2", {31'b0, req0}, 32'h1);
        @(negedge clk);
        #1;
        chk("arst resume valid", {31'b0, valid0}, 32'h1);
        chk("arst resume pc", pc0, 32'h0);
        chk("arst resume inst", inst0, 32'h8462_AC42);

        // Randomized run against the stream model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        m_next  = 32'h0;
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        m_valid = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            stall    = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else
                rpc = $urandom;
            #1;
            chk("rnd valid", {31'b0, valid0}, {31'b0, m_valid});
            chk("rnd inst", inst0, m_valid ? mem_word(m_pc) : 32'h0);
            chk("rnd pc", pc0, m_pc);
            chk("rnd pc4", pc4_0, m_pc + 32'd4);
            chk("rnd addr", addr0, m_next);
            chk("rnd req", {31'b0, req0},
                {31'b0, !stall && !redirect});
            chk("rnd cnt", cnt0, m_cnt);
            if (redirect) begin
                m_next  = rpc & 32'hFFFF_FFFC;
                m_valid = 1'b0;
            end else if (!stall) begin
                if (m_valid) m_cnt = m_cnt + 32'd1;
                m_pc    = m_next;
                m_next  = m_next + 32'd4;
                m_valid = 1'b1;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
Fetch stage directly upstream of the instruction-decode stage in the 32-bit MIPS-style core. It owns the PC and drives a synchronous-read instruction memory. It presents each fetched word with its PC and a valid bit straight to decode; the memory output register serves as the IF/ID register. It honours a stall from decode and a redirect (branch/jump/flush) from later stages, and keeps a count of delivered instructions.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.

Ports:
Clock        input   1   core clock; all state updates on rising edge
Reset        input   1   asynchronous, active-high reset
stall        input   1   decode cannot accept; hold everything
redirect     input   1   load redirect_pc, squash the word presented to decode
redirect_pc  input   32  new fetch byte address; bits [1:0] forced to 0
imem_addr    output  32  byte address to instruction memory (word aligned)
imem_req     output  1   memory read enable; rdata updates on next edge only when 1, otherwise holds
imem_rdata   input   32  memory read data, valid one cycle after the request
inst         output  32  instruction to decode; 32'h0 (NOP) when valid=0
pc           output  32  PC of inst
pc_plus4     output  32  pc+4, modulo 2^32
valid        output  1   inst/pc are a live instruction
fetch_count  output  32  instructions accepted by decode; wraps

Behaviour:
- Registers: fetch_pc, pc_d, fetch_count, and a 2-state FSM {EMPTY, FULL}. valid = (state==FULL).
- Async reset, with no clock edge needed:
  - fetch_pc=RESET_PC; pc_d=0; fetch_count=0; state=EMPTY.
  - While Reset is high: imem_req=0, valid=0, inst=0, pc=0, pc_plus4=4.
- Combinational outputs:
  - imem_addr = fetch_pc.
  - imem_req = !Reset && !stall && !redirect.
  - inst = valid ? imem_rdata : 32'h0.
- Per rising edge, in priority order:
  1. redirect=1 (whatever stall is): fetch_pc<=redirect_pc&~3; state<=EMPTY; pc_d unchanged. No read is issued this cycle. Target reaches decode 2 edges after the redirect edge (2-cycle bubble).
  2. stall=1: all registers hold. imem_req=0, so imem_rdata holds and inst/pc/valid stay stable. Applies in EMPTY and FULL.
  3. otherwise: pc_d<=fetch_pc; fetch_pc<=fetch_pc+4 (mod 2^32); state<=FULL.
- fetch_count increments on an edge where valid && !stall && !redirect; wraps at 2^32.
- FSM transitions:
  - EMPTY→FULL on a normal advance.
  - FULL→FULL on a normal advance or stall.
  - any→EMPTY on redirect.
  - EMPTY→EMPTY on stall.
- Latency: one cycle from address presented to valid inst. Steady state delivers one instruction per cycle.
- Boundaries:
  - redirect and stall in the same cycle: redirect wins; the stalled word is squashed.
  - redirect on consecutive cycles: the last target wins.
  - fetch_pc 0xFFFF_FFFC advances to 0x0000_0000.
  - Reset asserted mid-stream: outputs drop to reset values immediately; fetch restarts at RESET_PC.

Decomposition:
- Shared core package: constants PC_WIDTH=32, INST_WIDTH=32, NOP_INST=32'h0, DEFAULT_RESET_PC; fetch FSM state encoding (EMPTY/FULL).
- One natural sub-module: fetch_pc_gen (next-PC select among hold/+4/redirect, alignment, fetch_pc register).
- FSM, pc_d and counter stay in the top.

Test Plan:
1. RESET_PC=0x0040_0000; hold Reset 3 cycles, then release.
   - During Reset: valid=0, inst=0, imem_req=0.
   - First cycle after release: imem_addr=0x0040_0000, imem_req=1.
   - Next cycle: valid=1, pc=0x0040_0000, pc_plus4=0x0040_0004.
2. Memory word0=0x8462AC42, word1=0x8046AC02 at RESET_PC=0.
   - Consecutive cycles show inst=0x8462AC42 with pc=0, then inst=0x8046AC02 with pc=4.
   - fetch_count=2 after both are accepted.
3. stall high 3 cycles while FULL at pc=4.
   - inst, pc, valid and fetch_count are unchanged throughout; imem_req=0.
   - After release, the next word presented is pc=8.
4. redirect with redirect_pc=0x0000_0103.
   - Next cycle: valid=0, inst=0, imem_addr=0x100.
   - Following cycle: valid=1, pc=0x100.
   - fetch_count does not count the squashed word.
5. redirect and stall together with redirect_pc=0xFFFF_FFFC.
   - Redirect is taken; the held word is squashed.
   - Later: pc=0xFFFF_FFFC with pc_plus4=0, then pc=0x0000_0000.
6. Reset pulsed asynchronously between edges during a stream.
   - valid, fetch_count and pc go to 0 before the next edge.
   - Fetch resumes at RESET_PC after release.
